fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single outstanding instruction-memory request,
// a small circular buffer of {pc, word} entries toward decode, and redirect
// handling. A redirect that arrives while a request is still in flight is
// handled by waiting for that request's ack in DROP and discarding its data.
//
// Handshakes:
//   memory side : a transfer completes on a rising edge with imem_req=1 and
//                 imem_ack=1; imem_addr holds steady from request until ack;
//                 acks while imem_req=0 are ignored.
//   decode side : the head entry is consumed on a rising edge with
//                 inst_valid=1 and inst_ready=1; the head holds steady while
//                 inst_valid=1 and inst_ready=0.
// Debug: dbg_state exposes the FSM state (0 = IDLE, 1 = REQ, 2 = DROP).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_word,
  input  logic        inst_ready,
  output logic [1:0]  dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      buf_pc_q   [DEPTH];
  logic [31:0]      buf_word_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_after;

  logic        flush;
  logic        push;
  logic        pop;
  logic        slot_free;
  logic [31:0] redirect_target;
  logic [31:0] fetch_pc_inc;
  logic        unused_redirect_low;

  // The low two redirect bits are forced to zero; they carry no information.
  assign unused_redirect_low = ^redirect_pc[1:0];

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign fetch_pc_inc    = fetch_pc_q + 32'd4;

  // Redirect wins over everything: it empties the buffer and cancels
  // this cycle's push and pop.
  assign flush      = redirect_valid;
  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid & inst_ready & ~flush;
  assign push       = (state_q == S_REQ) & imem_ack & ~flush;

  // Occupancy after this edge's push/pop (ignoring flush); a simultaneous
  // push and pop leaves it unchanged even when the buffer is full.
  always_comb begin
    count_after = count_q;
    if (push && !pop) begin
      count_after = count_q + 1'b1;
    end else if (!push && pop) begin
      count_after = count_q - 1'b1;
    end
  end

  assign slot_free = (count_after < DEPTH_C);

  // Buffer bookkeeping: pointers and count, with flush equalising pointers.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_after;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Next-state logic for the request FSM, fetch PC and request address.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d    = S_REQ;
          fetch_pc_d = redirect_target;
          addr_d     = redirect_target;
        end else if (slot_free) begin
          state_d = S_REQ;
          addr_d  = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (flush) begin
          fetch_pc_d = redirect_target;
          if (imem_ack) begin
            // The in-flight request completes now; its data is dropped.
            state_d = S_REQ;
            addr_d  = redirect_target;
          end else begin
            // Keep the old request alive until memory acknowledges it.
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_inc;
          addr_d     = fetch_pc_inc;
          state_d    = slot_free ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (flush) begin
          fetch_pc_d = redirect_target;
        end
        if (imem_ack) begin
          // Stale data is discarded; restart at the newest target.
          state_d = S_REQ;
          addr_d  = flush ? redirect_target : fetch_pc_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC, address, pointer and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage: a completed fetch is written at the write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]   <= '0;
        buf_word_q[i] <= '0;
      end
    end else if (push) begin
      buf_pc_q[wr_ptr_q]   <= fetch_pc_q;
      buf_word_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = addr_q;
  assign inst_pc   = inst_valid ? buf_pc_q[rd_ptr_q]   : 32'd0;
  assign inst_word = inst_valid ? buf_word_q[rd_ptr_q] : 32'd0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed cycle table, hand-written corner
// sequences, and a randomized run scored against an instruction-stream model.
module tb_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_word;
  logic        inst_ready;
  logic [1:0]  dbg_state;

  int tests;
  int fails;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_word      (inst_word),
    .inst_ready     (inst_ready),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Holds reset for three cycles and releases it on a falling edge.
  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_ack       = 1'b0;
    inst_ready     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        ack;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  // ---------------- random-run scoreboard ----------------
  logic [63:0] exp_q[$];

  initial begin
    logic [31:0] exp_fetch;
    logic        drop_pending;
    logic        prev_req, prev_ack, prev_rv;
    logic [31:0] prev_addr;
    logic [63:0] head;
    logic [31:0] wrap_exp [2];
    int          found;
    int          acks;
    int          got;
    int          delivered;

    tests = 0;
    fails = 0;

    // Reset values while reset is held.
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_ack       = 1'b1;
    inst_ready     = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req",   32'(imem_req),   32'd0);
    check("rst_addr",  imem_addr,       RST_PC);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_pc",    inst_pc,         32'd0);
    check("rst_word",  inst_word,       32'd0);
    check("rst_state", 32'(dbg_state),  32'd0);

    // Stream, backpressure into a full buffer, resume, then drain.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h3004, 1'b1, 32'h3000};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h3008, 1'b1, 32'h3004};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h300C, 1'b1, 32'h3008};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h3008};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,    1'b1, 32'h3008};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h3010, 1'b1, 32'h300C};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h3010, 1'b1, 32'h300C};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h3010, 1'b1, 32'h300C};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h3014, 1'b1, 32'h3010};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h3014, 1'b0, 32'h0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      imem_ack   = vecs[i].ack;
      inst_ready = vecs[i].rdy;
      check($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req)
        check($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
      check($sformatf("tbl%0d_pc", i), inst_pc, vecs[i].exp_pc);
      check($sformatf("tbl%0d_word", i), inst_word,
            vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'd0);
      @(negedge clk);
    end

    // Backpressure: exactly two acks accepted, then idle; resume at 0x3008.
    do_reset();
    imem_ack   = 1'b1;
    inst_ready = 1'b0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      if (imem_req && imem_ack) acks++;
      @(negedge clk);
    end
    check("bp_acks",  32'(acks),       32'd2);
    check("bp_idle",  32'(imem_req),   32'd0);
    check("bp_head",  inst_pc,         32'h3000);
    imem_ack   = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_req",  32'(imem_req), 32'd1);
    check("bp_resume_addr", imem_addr,     32'h3008);
    check("bp_resume_head", inst_pc,       32'h3004);

    // Redirect while the request to 0x300C waits for its ack.
    do_reset();
    inst_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (imem_req && imem_addr == 32'h300C) begin
        found = 1;
        break;
      end
      imem_ack = 1'b1;
      @(negedge clk);
    end
    check("drop_reach", 32'(found), 32'd1);
    imem_ack       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4001;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("drop_state", 32'(dbg_state),  32'd2);
    check("drop_req",   32'(imem_req),   32'd1);
    check("drop_addr",  imem_addr,       32'h300C);
    check("drop_valid", 32'(inst_valid), 32'd0);
    imem_ack = 1'b1;
    @(negedge clk);
    check("drop_next_addr", imem_addr,       32'h4000);
    check("drop_discard",   32'(inst_valid), 32'd0);
    @(negedge clk);
    check("drop_first_valid", 32'(inst_valid), 32'd1);
    check("drop_first_pc",    inst_pc,         32'h4000);
    check("drop_first_word",  inst_word,       mem_word(32'h4000));

    // Redirect together with ack and pop while the buffer is full.
    do_reset();
    imem_ack   = 1'b1;
    inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("full_valid", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_5000;
    inst_ready     = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("flush_valid", 32'(inst_valid), 32'd0);
    check("flush_req",   32'(imem_req),   32'd1);
    check("flush_addr",  imem_addr,       32'h5000);
    @(negedge clk);
    check("flush_first_pc",   inst_pc,   32'h5000);
    check("flush_first_word", inst_word, mem_word(32'h5000));

    // Wrap of the fetch PC past the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    wrap_exp[0] = 32'hFFFF_FFFC;
    wrap_exp[1] = 32'h0000_0000;
    got = 0;
    for (int k = 0; k < 20 && got < 2; k++) begin
      if (inst_valid) begin
        check($sformatf("wrap_pc%0d", got), inst_pc, wrap_exp[got]);
        check($sformatf("wrap_word%0d", got), inst_word, mem_word(wrap_exp[got]));
        got++;
      end
      @(negedge clk);
    end
    check("wrap_count", 32'(got), 32'd2);

    // Asynchronous reset in the middle of a request.
    do_reset();
    imem_ack   = 1'b1;
    inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    imem_ack = 1'b0;
    check("mid_pre_req",   32'(imem_req),   32'd1);
    check("mid_pre_valid", 32'(inst_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_req",   32'(imem_req),   32'd0);
    check("mid_valid", 32'(inst_valid), 32'd0);
    imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("mid_rel_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("mid_first_req",   32'(imem_req),   32'd1);
    check("mid_first_addr",  imem_addr,       RST_PC);
    check("mid_first_valid", 32'(inst_valid), 32'd0);

    // Randomized run against the instruction-stream model.
    do_reset();
    exp_q.delete();
    exp_fetch    = RST_PC;
    drop_pending = 1'b0;
    prev_req     = 1'b0;
    prev_ack     = 1'b0;
    prev_rv      = 1'b0;
    prev_addr    = 32'd0;
    delivered    = 0;
    for (int c = 0; c < 2000; c++) begin
      imem_ack       = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;

      check("rnd_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("rnd_pc",   inst_pc,   head[63:32]);
        check("rnd_word", inst_word, head[31:0]);
      end
      if (prev_req && !prev_ack && imem_req)
        check("rnd_addr_stable", imem_addr, prev_addr);
      if (prev_rv)
        check("rnd_after_redirect", 32'(inst_valid), 32'd0);

      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_rv   = redirect_valid;
      prev_addr = imem_addr;

      if (redirect_valid) begin
        drop_pending = imem_req && !imem_ack;
        exp_q.delete();
        exp_fetch = {redirect_pc[31:2], 2'b00};
      end else begin
        if (exp_q.size() != 0 && inst_ready) begin
          void'(exp_q.pop_front());
          delivered++;
        end
        if (imem_req && imem_ack) begin
          if (drop_pending) begin
            drop_pending = 1'b0;
          end else begin
            check("rnd_fetch_addr", imem_addr, exp_fetch);
            exp_q.push_back({exp_fetch, mem_word(exp_fetch)});
            exp_fetch = exp_fetch + 32'd4;
            check("rnd_occupancy", 32'(exp_q.size() <= DEPTH), 32'd1);
          end
        end
      end
      @(negedge clk);
    end
    check("rnd_progress", 32'(delivered >= 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
